hpdcache_perf_cnt_bank: RTL and testbench

HPDCACHE_PERF_CNT_BANK -- requirements
Module: hpdcache_perf_cnt_bank

---
 rtl/hpdcache_perf_pkg.sv | 12 +
 rtl/hpdcache_perf_cnt.sv | 42 ++++
 rtl/hpdcache_perf_cnt_bank.sv | 120 ++++++++++++
 tb/tb_hpdcache_perf_cnt_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_perf_pkg.sv
// Shared types for the HPDcache performance counter bank: read FSM states and
// the event index used to address counters/shadows.
package hpdcache_perf_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  typedef logic [4:0] evt_idx_t;

endpackage

// File: rtl/hpdcache_perf_cnt.sv
// Single event counter with selectable saturate/wrap behaviour and a sticky
// overflow flag. Clear has priority over an increment in the same cycle.
module hpdcache_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clear_i,
  input  logic             saturate_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             at_max;

  assign at_max = (cnt_q == {CNT_W{1'b1}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (inc_i) begin
      if (at_max) begin
        // Overflow is flagged whether the counter holds or wraps.
        ovf_q <= 1'b1;
        cnt_q <= saturate_i ? cnt_q : '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/hpdcache_perf_cnt_bank.sv
// Bank of NB_EVT event counters with snapshot shadows, sticky overflow flags
// and a valid/ready read port returning one shadow value per request.
module hpdcache_perf_cnt_bank
  import hpdcache_perf_pkg::*;
#(
  parameter int unsigned NB_EVT = 11,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NB_EVT-1:0] evt_i,
  input  logic              cfg_enable_i,
  input  logic [NB_EVT-1:0] cfg_mask_i,
  input  logic              cfg_saturate_i,
  input  logic              clear_i,
  input  logic              snap_i,
  input  logic              rd_req_valid_i,
  output logic              rd_req_ready_o,
  input  logic [4:0]        rd_req_idx_i,
  output logic              rd_rsp_valid_o,
  input  logic              rd_rsp_ready_i,
  output logic [CNT_W-1:0]  rd_rsp_data_o,
  output logic              rd_rsp_err_o,
  output logic [NB_EVT-1:0] ovf_o,
  output logic              ovf_any_o
);

  logic [NB_EVT-1:0] inc;
  logic [CNT_W-1:0]  cnt      [NB_EVT];
  logic [CNT_W-1:0]  shadow_q [NB_EVT];

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_err_q;
  logic [CNT_W-1:0] rd_sel_data;
  logic             rd_sel_err;
  logic             rd_accept;

  assign inc = evt_i & cfg_mask_i & {NB_EVT{cfg_enable_i}};

  for (genvar k = 0; k < NB_EVT; k++) begin : g_cnt
    hpdcache_perf_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (inc[k]),
      .clear_i    (clear_i),
      .saturate_i (cfg_saturate_i),
      .cnt_o      (cnt[k]),
      .ovf_o      (ovf_o[k])
    );
  end

  assign ovf_any_o = |ovf_o;

  // Shadows take the registered (pre-increment, pre-clear) live values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_EVT; k++) shadow_q[k] <= '0;
    end else if (snap_i) begin
      for (int k = 0; k < NB_EVT; k++) shadow_q[k] <= cnt[k];
    end
  end

  // Index decode: anything not matching an implemented channel reports error.
  always_comb begin
    rd_sel_data = '0;
    rd_sel_err  = 1'b1;
    for (int k = 0; k < NB_EVT; k++) begin
      if (rd_req_idx_i == evt_idx_t'(k)) begin
        rd_sel_data = shadow_q[k];
        rd_sel_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_accept = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_req_valid_i) begin
          rd_accept = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rd_rsp_ready_i) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Response payload is captured once at accept, so later snapshots cannot
  // disturb a pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else if (rd_accept) begin
      rd_data_q <= rd_sel_data;
      rd_err_q  <= rd_sel_err;
    end
  end

  assign rd_req_ready_o = (state_q == RD_IDLE);
  assign rd_rsp_valid_o = (state_q == RD_RESP);
  assign rd_rsp_data_o  = rd_data_q;
  assign rd_rsp_err_o   = rd_err_q;

endmodule

// File: tb/tb_hpdcache_perf_cnt_bank.sv
// Directed bench for the performance counter bank (NB_EVT=11, CNT_W=8).
module tb_hpdcache_perf_cnt_bank;

  localparam int NB_EVT = 11;
  localparam int CNT_W  = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NB_EVT-1:0] evt_i;
  logic              cfg_enable_i;
  logic [NB_EVT-1:0] cfg_mask_i;
  logic              cfg_saturate_i;
  logic              clear_i;
  logic              snap_i;
  logic              rd_req_valid_i;
  logic              rd_req_ready_o;
  logic [4:0]        rd_req_idx_i;
  logic              rd_rsp_valid_o;
  logic              rd_rsp_ready_i;
  logic [CNT_W-1:0]  rd_rsp_data_o;
  logic              rd_rsp_err_o;
  logic [NB_EVT-1:0] ovf_o;
  logic              ovf_any_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  hpdcache_perf_cnt_bank #(
    .NB_EVT(NB_EVT),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .evt_i          (evt_i),
    .cfg_enable_i   (cfg_enable_i),
    .cfg_mask_i     (cfg_mask_i),
    .cfg_saturate_i (cfg_saturate_i),
    .clear_i        (clear_i),
    .snap_i         (snap_i),
    .rd_req_valid_i (rd_req_valid_i),
    .rd_req_ready_o (rd_req_ready_o),
    .rd_req_idx_i   (rd_req_idx_i),
    .rd_rsp_valid_o (rd_rsp_valid_o),
    .rd_rsp_ready_i (rd_rsp_ready_i),
    .rd_rsp_data_o  (rd_rsp_data_o),
    .rd_rsp_err_o   (rd_rsp_err_o),
    .ovf_o          (ovf_o),
    .ovf_any_o      (ovf_any_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      evt_i     = '0;
      evt_i[ch] = 1'b1;
      step();
    end
    evt_i = '0;
  endtask

  task automatic do_snap();
    snap_i = 1'b1;
    step();
    snap_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  // Issue one read and complete it; returns data/err of the response.
  task automatic rd(input int idx, output logic [CNT_W-1:0] data, output logic err);
    int n;
    check("rd_req_ready_idle", 64'(rd_req_ready_o), 64'd1);
    rd_req_idx_i   = 5'(idx);
    rd_req_valid_i = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!rd_rsp_valid_o && n < 8);
    rd_req_valid_i = 1'b0;
    if (!rd_rsp_valid_o) check("rd_rsp_timeout", 64'd0, 64'd1);
    data           = rd_rsp_data_o;
    err            = rd_rsp_err_o;
    rd_rsp_ready_i = 1'b1;
    step();
    rd_rsp_ready_i = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int idx, input int exp_data, input logic exp_err);
    logic [CNT_W-1:0] d;
    logic             e;
    rd(idx, d, e);
    check({tag, "_data"}, 64'(d), 64'(exp_data));
    check({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  initial begin
    rst_ni         = 1'b0;
    evt_i          = '0;
    cfg_enable_i   = 1'b1;
    cfg_mask_i     = '1;
    cfg_saturate_i = 1'b1;
    clear_i        = 1'b0;
    snap_i         = 1'b0;
    rd_req_valid_i = 1'b0;
    rd_req_idx_i   = '0;
    rd_rsp_ready_i = 1'b0;
    repeat (2) step();

    check("rst_req_ready", 64'(rd_req_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rd_rsp_valid_o), 64'd0);
    check("rst_rsp_data", 64'(rd_rsp_data_o), 64'd0);
    check("rst_rsp_err", 64'(rd_rsp_err_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    rst_ni = 1'b1;
    step();
    rd_check("rst_shadow3", 3, 0, 1'b0);

    // Basic count/snap/read on channel 3.
    pulse(3, 5);
    do_snap();
    rd_check("ch3_five", 3, 5, 1'b0);
    rd_check("ch2_zero", 2, 0, 1'b0);
    check("ch3_no_ovf", 64'(ovf_any_o), 64'd0);

    // Index boundary: 10 is the last channel, 11 and 20 are out of range.
    rd_check("idx10", 10, 0, 1'b0);
    rd_check("idx11", 11, 0, 1'b1);
    rd_check("idx20", 20, 0, 1'b1);

    // Per-channel mask and global enable gate counting.
    cfg_mask_i[4] = 1'b0;
    pulse(4, 3);
    cfg_mask_i   = '1;
    cfg_enable_i = 1'b0;
    pulse(5, 2);
    cfg_enable_i = 1'b1;
    do_snap();
    rd_check("masked_ch4", 4, 0, 1'b0);
    rd_check("disabled_ch5", 5, 0, 1'b0);

    // Saturate mode: 300 pulses hold at 255 with overflow set.
    do_clear();
    pulse(0, 300);
    do_snap();
    rd_check("sat_ch0", 0, 255, 1'b0);
    check("sat_ovf0", 64'(ovf_o), 64'h1);
    check("sat_ovf_any", 64'(ovf_any_o), 64'd1);
    rd_check("sat_ch3_cleared", 3, 0, 1'b0);
    check("ovf_sticky", 64'(ovf_o), 64'h1);

    // Wrap mode: overflow only on the 256th increment, final value 44.
    do_clear();
    check("clr_ovf", 64'(ovf_o), 64'd0);
    cfg_saturate_i = 1'b0;
    pulse(0, 255);
    check("wrap_255_no_ovf", 64'(ovf_o), 64'd0);
    pulse(0, 1);
    check("wrap_256_ovf", 64'(ovf_o), 64'h1);
    do_snap();
    rd_check("wrap_ch0_zero", 0, 0, 1'b0);
    pulse(0, 44);
    do_snap();
    rd_check("wrap_ch0_44", 0, 44, 1'b0);
    check("wrap_ovf_sticky", 64'(ovf_o), 64'h1);

    // Clear wins over a simultaneous event; shadow keeps its old value.
    pulse(1, 7);
    do_snap();
    evt_i   = 11'b000_0000_0010;
    clear_i = 1'b1;
    step();
    evt_i   = '0;
    clear_i = 1'b0;
    check("clr_evt_ovf", 64'(ovf_o), 64'd0);
    rd_check("clr_shadow_kept", 1, 7, 1'b0);
    do_snap();
    rd_check("clr_evt_ch1", 1, 0, 1'b0);

    // Clear and snap together capture pre-clear values.
    pulse(2, 4);
    clear_i = 1'b1;
    snap_i  = 1'b1;
    step();
    clear_i = 1'b0;
    snap_i  = 1'b0;
    rd_check("clr_snap_ch2", 2, 4, 1'b0);
    do_snap();
    rd_check("post_clr_ch2", 2, 0, 1'b0);

    // Back-pressured response stays stable while counting and snapping go on.
    pulse(6, 3);
    do_snap();
    rd_req_idx_i   = 5'd6;
    rd_req_valid_i = 1'b1;
    step();
    rd_req_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      evt_i  = (i < 2) ? 11'b000_0100_0000 : '0;
      snap_i = (i == 2);
      check("bp_valid", 64'(rd_rsp_valid_o), 64'd1);
      check("bp_req_ready", 64'(rd_req_ready_o), 64'd0);
      check("bp_data", 64'(rd_rsp_data_o), 64'd3);
      step();
    end
    evt_i  = '0;
    snap_i = 1'b0;
    check("bp_data_end", 64'(rd_rsp_data_o), 64'd3);
    rd_rsp_ready_i = 1'b1;
    step();
    rd_rsp_ready_i = 1'b0;
    check("bp_back_idle", 64'(rd_req_ready_o), 64'd1);
    rd_check("bp_new_snap", 6, 5, 1'b0);

    // Asynchronous reset in the middle of a pending response.
    pulse(7, 4);
    do_snap();
    rd_req_idx_i   = 5'd7;
    rd_req_valid_i = 1'b1;
    step();
    rd_req_valid_i = 1'b0;
    check("mid_rsp_data", 64'(rd_rsp_data_o), 64'd4);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(rd_rsp_valid_o), 64'd0);
    check("arst_req_ready", 64'(rd_req_ready_o), 64'd1);
    check("arst_rsp_data", 64'(rd_rsp_data_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    check("arst_no_rsp", 64'(rd_rsp_valid_o), 64'd0);
    do_snap();
    rd_check("arst_ch7", 7, 0, 1'b0);
    rd_check("arst_ch6", 6, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
